// File: rtl/ysyx_24080014_fetch_seq.sv
// ysyx_24080014_fetch_seq: multi-cycle fetch/exec sequencer that owns the PC and stops on faults or halt
// ports: ifu_req_* fetch request, ifu_rsp_* fetch response, inst/inst_valid to execute,
// exu_done/next_pc/halt_req from execute, pc/commit/instret/halted/fault status
module ysyx_24080014_fetch_seq #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_req_valid,
  input  logic        ifu_req_ready,
  output logic [31:0] ifu_req_addr,
  input  logic        ifu_rsp_valid,
  output logic        ifu_rsp_ready,
  input  logic [31:0] ifu_rsp_inst,
  input  logic        ifu_rsp_err,
  output logic [31:0] inst,
  output logic        inst_valid,
  input  logic        exu_done,
  input  logic [31:0] next_pc,
  input  logic        halt_req,
  output logic [31:0] pc,
  output logic        commit,
  output logic [63:0] instret,
  output logic        halted,
  output logic [1:0]  fault
);
  typedef enum logic [1:0] {FETCH_REQ, FETCH_RSP, EXEC, HALT} state_t;
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, inst_q, inst_d;
  logic [63:0] instret_q, instret_d;
  logic [1:0] fault_q, fault_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic inst_valid_q, inst_valid_d, commit_q, commit_d;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    inst_d = inst_q;
    instret_d = instret_q;
    fault_d = fault_q;
    cnt_d = cnt_q;
    inst_valid_d = 1'b0;
    commit_d = 1'b0;
    case (state_q)
      FETCH_REQ: if (ifu_req_ready) begin
        state_d = FETCH_RSP;
        cnt_d = '0;
      end
      FETCH_RSP: begin
        cnt_d = cnt_q + 1'b1;
        // a response in the last allowed cycle wins over the timeout
        if (ifu_rsp_valid) begin
          state_d = ifu_rsp_err ? HALT : EXEC;
          fault_d = ifu_rsp_err ? 2'b01 : fault_q;
          inst_d = ifu_rsp_err ? inst_q : ifu_rsp_inst;
          inst_valid_d = !ifu_rsp_err;
        end else if (cnt_q == CNT_MAX) begin
          state_d = HALT;
          fault_d = 2'b10;
        end
      end
      EXEC: if (exu_done) begin
        if (halt_req) begin
          commit_d = 1'b1;
          instret_d = instret_q + 64'd1;
          state_d = HALT;
        end else if (next_pc[1:0] != 2'b00) begin
          state_d = HALT;
          fault_d = 2'b11;
        end else begin
          pc_d = next_pc;
          commit_d = 1'b1;
          instret_d = instret_q + 64'd1;
          state_d = FETCH_REQ;
        end
      end
      HALT: ;
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH_REQ;
      pc_q <= RESET_PC;
      inst_q <= '0;
      instret_q <= '0;
      fault_q <= 2'b00;
      cnt_q <= '0;
      inst_valid_q <= 1'b0;
      commit_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      inst_q <= inst_d;
      instret_q <= instret_d;
      fault_q <= fault_d;
      cnt_q <= cnt_d;
      inst_valid_q <= inst_valid_d;
      commit_q <= commit_d;
    end
  end
  // gated by rst so no request is presented while reset is held
  assign ifu_req_valid = state_q == FETCH_REQ && !rst;
  assign ifu_req_addr = pc_q;
  assign ifu_rsp_ready = state_q == FETCH_RSP;
  assign inst = inst_q;
  assign inst_valid = inst_valid_q;
  assign pc = pc_q;
  assign commit = commit_q;
  assign instret = instret_q;
  assign halted = state_q == HALT;
  assign fault = fault_q;
endmodule

// File: doc/ysyx_24080014_fetch_seq.md
# ysyx_24080014_fetch_seq

Multi-cycle instruction sequencer for the NPC core. It owns the architectural PC register and fetches each instruction over a valid/ready handshake to instruction memory. It presents the instruction to the execute stage, waits for execute completion and commits the next PC supplied by the jump/next-PC unit. It also detects fetch errors, fetch timeouts, misaligned next PCs and halt requests, and stops the core cleanly on any of them.

## Interface
- RESET_PC, 32'h8000_0000, PC value loaded on reset
- TIMEOUT, 1024, maximum cycles spent in FETCH_RSP before a timeout fault; must be ≥ 2

- clk  in  1  core clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ifu_req_valid  out  1  fetch request valid
- ifu_req_ready  in  1  memory accepts request
- ifu_req_addr  out  32  fetch address (= pc)
- ifu_rsp_valid  in  1  fetch response valid
- ifu_rsp_ready  out  1  sequencer accepts response
- ifu_rsp_inst  in  32  fetched instruction word
- ifu_rsp_err  in  1  bus error on this response
- inst  out  32  latched instruction, held stable through EXEC
- inst_valid  out  1  one-cycle pulse on first EXEC cycle
- exu_done  in  1  execute stage finished; next_pc/halt_req valid this cycle
- next_pc  in  32  next PC from jump unit (trap/mret/jal/jalr/pc+4 already resolved)
- halt_req  in  1  current instruction is ebreak
- pc  out  32  architectural PC of current instruction
- commit  out  1  one-cycle pulse when an instruction retires
- instret  out  64  retired-instruction counter
- halted  out  1  sequencer in HALT
- fault  out  2  00 none, 01 fetch error, 10 fetch timeout, 11 misaligned next_pc

## Operation
- States: FETCH_REQ, FETCH_RSP, EXEC, HALT. Reset state is FETCH_REQ.
- FETCH_REQ
  - ifu_req_valid=1, ifu_req_addr=pc.
  - On ifu_req_ready, go to FETCH_RSP and clear the timeout counter.
  - valid and addr stay stable until accepted; no retraction.
- FETCH_RSP
  - ifu_rsp_ready=1; the timeout counter increments each cycle.
  - On ifu_rsp_valid with ifu_rsp_err=1: go to HALT, fault=01, inst unchanged.
  - On ifu_rsp_valid with ifu_rsp_err=0: inst<=ifu_rsp_inst, go to EXEC.
  - If the counter reaches TIMEOUT-1 without a response: go to HALT, fault=10. A response arriving in that same cycle takes priority.
- EXEC
  - inst_valid=1 on the first EXEC cycle only; the sequencer waits for exu_done.
  - On exu_done the first matching case applies:
    - halt_req=1: commit pulse, instret+1, pc unchanged, go to HALT, fault stays 00.
    - next_pc[1:0]!=0: no commit, pc unchanged, go to HALT, fault=11.
    - Otherwise: pc<=next_pc, commit pulse, instret+1, go to FETCH_REQ.
- HALT is absorbing until rst. halted=1; every handshake output is 0; exu_done, ifu_* and halt_req are ignored.
- Out-of-state inputs are ignored: ifu_req_ready outside FETCH_REQ, ifu_rsp_valid outside FETCH_RSP, exu_done outside EXEC.
- instret wraps modulo 2^64.

## Timing
- Reset values while rst=1 and in the cycle after:
  - pc=RESET_PC, inst=0, instret=0, fault=00, halted=0.
  - inst_valid=0, commit=0, ifu_rsp_ready=0.
  - ifu_req_valid is gated by !rst, so it is 0 during reset and 1 in the first cycle after deassertion.
- Outputs are Moore, decoded from registered state. commit and inst_valid are registered pulses; commit appears in the cycle after exu_done is sampled.
- pc updates on the edge that samples exu_done. The pc value is visible to the next FETCH_REQ in the same cycle as commit.
- Minimum throughput is 3 cycles per instruction (ready, rsp_valid and exu_done each high on first opportunity).
- Reset asserted mid-operation (any state, including HALT) aborts the operation. Any outstanding request or response is dropped, and the memory side must tolerate this.

## Test plan
- Reset then zero-wait memory with exu_done in the first EXEC cycle and next_pc=pc+4:
  - ifu_req_addr sequence is 0x80000000, 0x80000004, 0x80000008.
  - commit fires every 3 cycles; instret=3 after three commits.
- Memory ready delayed 4 cycles and response delayed 5:
  - addr is stable while waiting.
  - inst equals the response word; inst_valid is a single pulse.
  - exu_done injected during FETCH_RSP is ignored.
- next_pc=0x80000100, then next_pc=0x80000102:
  - First instruction: pc becomes 0x80000100 and commit fires.
  - Second instruction: HALT with fault=11, pc stays 0x80000100, no commit.
- Response with ifu_rsp_err=1 gives fault=01 and halted=1. With TIMEOUT=8 and no response, fault=10 after exactly 8 FETCH_RSP cycles.
- halt_req with exu_done: commit pulse, instret+1, halted=1, fault=00. Later ifu_req_ready and exu_done toggles cause no activity.
- rst pulsed in EXEC and in HALT: next cycle pc=0x80000000, instret=0, fault=00, ifu_req_valid=1.
